// File: rtl/pulse_generator.sv
// ============================================================================
// Module   : pulse_generator
// Brief    : Turns each rising edge of a level trigger into a fixed-width,
//            clock-synchronous output pulse. Optional input synchroniser,
//            retrigger policy and post-pulse holdoff window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_generator #(
  parameter int SYNC_STAGES = 0,
  parameter int PULSE_WIDTH = 1,
  parameter int HOLDOFF     = 0,
  parameter int RETRIGGER   = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  output logic pulse
);

  // Counter must hold PULSE_WIDTH-1 and HOLDOFF-1; floor of 2 keeps it >= 1 bit.
  localparam int c_MAXV = (PULSE_WIDTH > HOLDOFF) ?
                          ((PULSE_WIDTH > 2) ? PULSE_WIDTH : 2) :
                          ((HOLDOFF > 2) ? HOLDOFF : 2);
  localparam int c_CW   = $clog2(c_MAXV);

  localparam int c_HO_M1 = (HOLDOFF > 0) ? (HOLDOFF - 1) : 0;

  localparam logic [c_CW-1:0] c_PW_LOAD = c_CW'(PULSE_WIDTH - 1);
  localparam logic [c_CW-1:0] c_HO_LOAD = c_CW'(c_HO_M1);
  localparam logic [c_CW-1:0] c_ONE     = c_CW'(1);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_ACTIVE  = 2'd1;
  localparam logic [1:0] c_HOLDOFF = 2'd2;

  logic            w_trig_s;
  logic            w_edge;
  logic            r_trig_prev;
  logic [1:0]      r_state;
  logic [c_CW-1:0] r_cnt;
  logic            r_pulse;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_trig_s = trigger;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;

      // Shift the raw trigger through SYNC_STAGES flops before edge detection.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= trigger;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            r_sync[k] <= r_sync[k-1];
          end
        end
      end

      assign w_trig_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // A rising edge is the current sample high while the previous one was low.
  assign w_edge = w_trig_s & ~r_trig_prev;

  // Previous sample tracks every cycle in every state, so a level held through
  // ACTIVE or HOLDOFF can never look like a fresh edge later on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trig_prev <= 1'b0;
    end else begin
      r_trig_prev <= w_trig_s;
    end
  end

  // Pulse FSM: width countdown in ACTIVE, optional ignore window in HOLDOFF.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_edge) begin
            r_pulse <= 1'b1;
            r_cnt   <= c_PW_LOAD;
            r_state <= c_ACTIVE;
          end
        end
        c_ACTIVE: begin
          // A retrigger reload wins over expiry so the pulse never drops low.
          if ((RETRIGGER != 0) && w_edge) begin
            r_cnt <= c_PW_LOAD;
          end else if (r_cnt == '0) begin
            r_pulse <= 1'b0;
            if (HOLDOFF > 0) begin
              r_cnt   <= c_HO_LOAD;
              r_state <= c_HOLDOFF;
            end else begin
              r_state <= c_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - c_ONE;
          end
        end
        c_HOLDOFF: begin
          // Edges seen here are dropped, including one in the final cycle.
          if (r_cnt == '0) begin
            r_state <= c_IDLE;
          end else begin
            r_cnt <= r_cnt - c_ONE;
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_cnt   <= '0;
          r_pulse <= 1'b0;
        end
      endcase
    end
  end

  assign pulse = r_pulse;

endmodule

`default_nettype wire

// File: tb/tb_pulse_generator.sv
// ============================================================================
// Module   : tb_pulse_generator
// Brief    : Self-checking bench for pulse_generator. Six instances cover the
//            default edge detector, width with/without retrigger, holdoff,
//            reset mid-pulse and the input synchroniser.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_generator;

  logic       clk;
  logic [5:0] trig;
  logic [5:0] rst;
  logic [5:0] pulse;

  int n_cmp;
  int n_err;
  bit sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: defaults
  pulse_generator u_def (.clk(clk), .rst(rst[0]), .trigger(trig[0]), .pulse(pulse[0]));
  // 1: width 4, no retrigger
  pulse_generator #(.PULSE_WIDTH(4), .RETRIGGER(0)) u_w4 (
    .clk(clk), .rst(rst[1]), .trigger(trig[1]), .pulse(pulse[1]));
  // 2: width 4, retrigger
  pulse_generator #(.PULSE_WIDTH(4), .RETRIGGER(1)) u_w4r (
    .clk(clk), .rst(rst[2]), .trigger(trig[2]), .pulse(pulse[2]));
  // 3: width 2, holdoff 3
  pulse_generator #(.PULSE_WIDTH(2), .HOLDOFF(3)) u_ho (
    .clk(clk), .rst(rst[3]), .trigger(trig[3]), .pulse(pulse[3]));
  // 4: width 8
  pulse_generator #(.PULSE_WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst[4]), .trigger(trig[4]), .pulse(pulse[4]));
  // 5: two synchroniser stages
  pulse_generator #(.SYNC_STAGES(2)) u_sync (
    .clk(clk), .rst(rst[5]), .trigger(trig[5]), .pulse(pulse[5]));

  task automatic chk(input string tag, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  // Per cycle: drive trigger/rst at negedge and push the expected pulse for
  // that cycle; just after the next posedge pop it and compare.
  // Strings are indexed by cycle; a short rst string means rst stays low.
  task automatic run(input int sel, input string tag, input string t,
                     input string r, input string e);
    bit exp_v;
    for (int i = 0; i < t.len(); i++) begin
      @(negedge clk);
      trig[sel] = (t[i] == "1");
      rst[sel]  = (i < r.len()) ? (r[i] == "1") : 1'b0;
      sb.push_back(e[i] == "1");
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s[%0d]: scoreboard empty", tag, i);
      end else begin
        exp_v = sb.pop_front();
        chk($sformatf("%s[%0d]", tag, i), pulse[sel], exp_v);
      end
    end
    rst[sel] = 1'b0;
  endtask

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    trig  = '0;
    rst   = '1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("reset_u%0d", k), pulse[k], 1'b0);
    end
    @(negedge clk);
    rst = '0;
    repeat (2) @(negedge clk);

    // Defaults: held two cycles gives one 1-cycle pulse at first high sample.
    run(0, "def_hold",  "01100000",  "", "01000000");
    // Defaults: two short triggers, pulses 3 cycles apart.
    run(0, "def_rep",   "001001000", "", "001001000");
    // Defaults: trigger held through reset release gives exactly one pulse.
    run(0, "def_rstrel", "1111100",  "1100000", "0010000");
    // Width 4, second edge ignored.
    run(1, "w4_nort",   "1010000000", "", "1111000000");
    // Width 4, retrigger extends to cycles 0-5.
    run(2, "w4_rt",     "1010000000", "", "1111110000");
    // Width 2 holdoff 3: edge at 3 ignored, edge at 6 accepted.
    run(3, "ho_win",    "1001001000000", "", "1100001100000");
    // Edge in the final holdoff cycle is dropped, not queued.
    run(3, "ho_last",   "100001000000",  "", "110000000000");
    // Width 8, reset at cycle 3, trigger held: one fresh full pulse after.
    run(4, "w8_rst",    "1111111111111111", "0001000000000000",
                        "1110111111110000");
    // Two sync stages: pulse two cycles later than the direct case.
    run(5, "sync2",     "0110000000", "", "0001000000");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
